// File: rtl/store_narrow_rmw.sv
// Narrows sw/sh/sb stores onto word-wide memory without byte enables by doing
// a read-modify-write; big-endian lane order, bounded wait on every access.
module store_narrow_rmw #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic [1:0]  st_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Counter is sized so it can hold TIMEOUT; a zero TIMEOUT disables the abort.
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [1:0]    state;
  logic [1:0]    op_q;
  logic [1:0]    lane_q;
  logic [31:0]   data_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          aligned;
  logic          timed_out;
  logic [31:0]   merged;

  assign st_ready  = (state == IDLE);
  assign cnt_inc   = cnt + CW'(1);
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == LIMIT);

  always_comb begin
    aligned = 1'b0;
    case (st_op)
      2'b00:   aligned = (st_addr[1:0] == 2'b00);
      2'b01:   aligned = (st_addr[0] == 1'b0);
      2'b10:   aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
  end

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    merged = mem_rdata;
    if (op_q == 2'b10) begin
      case (lane_q)
        2'd0:    merged[31:24] = data_q[7:0];
        2'd1:    merged[23:16] = data_q[7:0];
        2'd2:    merged[15:8]  = data_q[7:0];
        default: merged[7:0]   = data_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[15:0] = data_q[15:0];
    end else begin
      merged[31:16] = data_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      lane_q    <= 2'b00;
      data_q    <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      st_done   <= 1'b0;
      st_err    <= 2'b00;
    end else begin
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            op_q   <= st_op;
            lane_q <= st_addr[1:0];
            data_q <= st_data;
            cnt    <= '0;
            if (!aligned) begin
              state   <= DONE;
              st_done <= 1'b1;
              st_err  <= 2'b01;
            end else if (st_op == 2'b00) begin
              state     <= WRITE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= st_data;
            end else begin
              state    <= READ;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {st_addr[31:2], 2'b00};
            end
          end
        end
        READ, WRITE: begin
          if (mem_ack) begin
            cnt <= '0;
            if (state == READ) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= merged;
            end else begin
              state     <= DONE;
              st_done   <= 1'b1;
              st_err    <= 2'b00;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
            end
          end else if (timed_out) begin
            state     <= DONE;
            st_done   <= 1'b1;
            st_err    <= 2'b10;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state  <= IDLE;
          st_err <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: table of stores against a memory responder with
// programmable ack delay, expectations queued at accept and checked at st_done.
module tb_store_narrow_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [1:0]  st_op = 2'b00;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_done;
  logic [1:0]  st_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  store_narrow_rmw #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_done(st_done), .st_err(st_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mem_init;
    int          d;
    logic [1:0]  err;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    int          lat;
    int          reqc;
  } vec_t;

  typedef struct {
    logic [1:0]  err;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    logic [31:0] waddr;
    int          lat;
    int          reqc;
    int          acc;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [31:0] mem [logic [31:0]];

  int          delay = 0;
  int          wcnt = 0;
  bit          in_acc = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          reqc = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder and completion monitor, both sampled mid-cycle.
  always @(negedge clk) begin
    bit prev_ack;
    exp_t e;
    prev_ack = mem_ack;
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      in_acc  = 0;
      wcnt    = 0;
    end else begin
      if (!in_acc || prev_ack) begin
        cap_we   = mem_we;
        cap_addr = mem_addr;
        cap_wd   = mem_wdata;
        in_acc   = 1;
        wcnt     = 0;
      end else begin
        chk("stable_we", 32'(mem_we), 32'(cap_we));
        chk("stable_addr", mem_addr, cap_addr);
        if (mem_we) chk("stable_wdata", mem_wdata, cap_wd);
      end
      reqc++;
      if (wcnt == delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          n_wr++;
          wr_addr = mem_addr;
          wr_data = mem_wdata;
          mem[mem_addr] = mem_wdata;
        end else begin
          n_rd++;
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end
      end else begin
        mem_ack = 1'b0;
      end
      wcnt++;
    end
    if (st_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got st_done=1 err=%b expected no completion (cycle %0d)", st_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("err", 32'(st_err), 32'(e.err));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("reads", 32'(n_rd), 32'(e.nrd));
        chk("writes", 32'(n_wr), 32'(e.nwr));
        chk("req_cycles", 32'(reqc), 32'(e.reqc));
        if (e.nwr != 0) begin
          chk("wdata", wr_data, e.wdata);
          chk("waddr", wr_addr, e.waddr);
        end
      end
    end
  end

  task automatic start_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    chk("ready_idle", 32'(st_ready), 32'd1);
    mem[{v.addr[31:2], 2'b00}] = v.mem_init;
    delay = v.d;
    n_rd = 0; n_wr = 0; reqc = 0; wr_addr = '0; wr_data = '0;
    st_valid = 1'b1;
    st_op    = v.op;
    st_addr  = v.addr;
    st_data  = v.data;
    e.err = v.err; e.nrd = v.nrd; e.nwr = v.nwr; e.wdata = v.wdata;
    e.waddr = {v.addr[31:2], 2'b00}; e.lat = v.lat; e.reqc = v.reqc; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no st_done expected completion within 60 cycles");
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    start_vec(v);
    @(negedge clk);
    st_valid = 1'b0;
    wait_done();
  endtask

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    //          op     addr        data          mem_init      d    err   rd wr  wdata         lat reqc
    vecs[0]  = '{2'b10, 32'h102, 32'h000000AB, 32'h11223344, 0,   2'b00, 1, 1, 32'h1122AB44, 3, 2};
    vecs[1]  = '{2'b01, 32'h106, 32'h1234BEEF, 32'hAABBCCDD, 0,   2'b00, 1, 1, 32'hAABBBEEF, 3, 2};
    vecs[2]  = '{2'b01, 32'h104, 32'h1234BEEF, 32'hAABBCCDD, 0,   2'b00, 1, 1, 32'hBEEFCCDD, 3, 2};
    vecs[3]  = '{2'b00, 32'h200, 32'hDEADBEEF, 32'h0,        3,   2'b00, 0, 1, 32'hDEADBEEF, 5, 4};
    vecs[4]  = '{2'b01, 32'h101, 32'h0000FFFF, 32'h0,        0,   2'b01, 0, 0, 32'h0,        1, 0};
    vecs[5]  = '{2'b11, 32'h100, 32'h12345678, 32'h0,        0,   2'b01, 0, 0, 32'h0,        1, 0};
    vecs[6]  = '{2'b10, 32'h100, 32'h00000077, 32'h55555555, 255, 2'b10, 0, 0, 32'h0,        5, 4};
    vecs[7]  = '{2'b10, 32'h103, 32'h1234565A, 32'hFFFFFFFF, 1,   2'b00, 1, 1, 32'hFFFFFF5A, 5, 4};
    vecs[8]  = '{2'b10, 32'h101, 32'hFFFFFFC3, 32'h00000000, 0,   2'b00, 1, 1, 32'h00C30000, 3, 2};
    vecs[9]  = '{2'b00, 32'h20E, 32'h0BADF00D, 32'h0,        0,   2'b01, 0, 0, 32'h0,        1, 0};
    vecs[10] = '{2'b01, 32'h104, 32'h0000CAFE, 32'h01020304, 3,   2'b00, 1, 1, 32'hCAFE0304, 9, 8};

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_done", 32'(st_done), 32'd0);
    chk("rst_err", 32'(st_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Requests raised while busy must be dropped, not queued.
    v = '{2'b01, 32'h106, 32'h00001111, 32'h22223333, 2, 2'b00, 1, 1, 32'h22221111, 7, 6};
    start_vec(v);
    @(negedge clk);
    st_op = 2'b00; st_addr = 32'h400; st_data = 32'h99999999;
    @(negedge clk);
    chk("busy_not_ready", 32'(st_ready), 32'd0);
    @(negedge clk);
    st_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("ignored_req", 32'(mem.exists(32'h400)), 32'd0);

    // Reset in the middle of a read wait abandons the store silently.
    @(negedge clk);
    delay = 255;
    n_rd = 0; n_wr = 0; reqc = 0;
    st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h100; st_data = 32'h000000EE;
    @(negedge clk);
    st_valid = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_done", 32'(st_done), 32'd0);
    rst = 1'b0;
    chk("midrst_ready", 32'(st_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_no_write", 32'(n_wr), 32'd0);
    v = '{2'b00, 32'h300, 32'hFEEDC0DE, 32'h0, 0, 2'b00, 0, 1, 32'hFEEDC0DE, 2, 1};
    run_vec(v);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
